fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Program-counter and fetch-control stage directly upstream of instruction_memory.
//   Drives the address that memory registers on each clk edge, and tracks which PC the
//   registered instruction belongs to plus whether it is valid. Supports stall replay,
//   taken-branch redirect with no bubble, and halt. Downstream decode consumes
//   instruction + inst_pc + inst_valid.
// PARAMETERS
//   ADDR_BITS   8     width of pc / branch_target / inst_pc; must equal memory MEMORY_BITS
//   RESET_PC    0     first address fetched after reset
//   COUNT_BITS  16    width of fetch_count (used only with FETCH_COUNT_EN)
// PORTS
//   clk            in   1          single clock; all state updates on posedge
//   rst            in   1          asynchronous, active-high reset
//   stall          in   1          downstream not consuming current valid instruction
//   branch_taken   in   1          redirect fetch this cycle
//   branch_target  in   ADDR_BITS  redirect address
//   halt           in   1          stop fetching until rst
//   pc             out  ADDR_BITS  address to instruction_memory (combinational, see below)
//   inst_pc        out  ADDR_BITS  address of instruction currently at memory output
//   inst_valid     out  1          memory output is a real instruction
//   halted         out  1          high in HALTED state
//   fetch_count    out  COUNT_BITS only with FETCH_COUNT_EN
// BEHAVIOUR
//   Regs: next_pc, inst_pc, inst_valid, state {BOOT,RUN,HALTED}. Memory latency 1 cycle:
//   address on pc at edge k appears as instruction after edge k.
//   Reset (async, immediate): state=BOOT, next_pc=RESET_PC, inst_pc=RESET_PC,
//   inst_valid=0, halted=0, fetch_count=0; pc therefore reads RESET_PC during reset.
//   pc mux (priority): HALTED -> next_pc; branch_taken -> branch_target;
//   stall && inst_valid -> inst_pc (replay, memory output unchanged); else next_pc.
//   BOOT: one cycle; edge -> RUN, inst_pc<=RESET_PC, inst_valid<=1, next_pc<=RESET_PC+1.
//   RUN, per edge, priority halt > branch > stall > advance:
//     halt: -> HALTED, inst_valid<=0, next_pc held, halted<=1 (branch/stall ignored).
//     branch: inst_pc<=branch_target, inst_valid<=1, next_pc<=branch_target+1; overrides stall.
//     stall with inst_valid=1: inst_pc, inst_valid, next_pc all held.
//     stall with inst_valid=0: treated as advance (fills the empty slot).
//     advance: inst_pc<=next_pc, inst_valid<=1, next_pc<=next_pc+1.
//   HALTED: all regs held, inst_valid=0, halted=1; exits only via rst.
//   Arithmetic: next_pc increments modulo 2**ADDR_BITS (max -> 0), no flag, no trap.
//   rst mid-stall/mid-branch: reset values win immediately; no partial update.
// CONFIGURATION
//   FETCH_COUNT_EN defined: fetch_count port present; +1 on each RUN/BOOT edge loading a
//   new valid instruction (advance, branch, BOOT); not on held stall or HALTED;
//   saturates at all-ones. Undefined: port and counter absent; all else identical.
// STRUCTURE
//   Shared package redux_v_pkg: fetch_state_t enum {BOOT,RUN,HALTED}, default ADDR_BITS
//   and RESET_PC constants shared with instruction_memory.
//   One sub-module: fetch_perf_counter (saturating counter), instantiated only under
//   FETCH_COUNT_EN. PC mux and FSM stay in fetch_unit.
// TESTING (bench pairs fetch_unit with instruction_memory, rom[i]=i^8'hA5)
//   Reset release: cycle0 inst_valid=0, pc=0; then inst_pc 0,1,2 valid, instruction A5,A4,A7.
//   Stall 3 cycles at inst_pc=5: pc=5, instruction=A0 held, inst_pc=5; release -> inst_pc=6.
//   branch_taken+stall at inst_pc=3, target 8'h40: pc=40 that cycle; next inst_pc=40 valid, pc=41.
//   RESET_PC=8'hFE: inst_pc FE, FF, 00, 01 all valid; no stall inserted at wrap.
//   halt at inst_pc=7: next cycle inst_valid=0, halted=1, pc=8 frozen; branch ignored; rst -> pc=0.
//   FETCH_COUNT_EN: 10 advances, 2 stall cycles, 1 branch -> fetch_count=12 (incl. BOOT).

Source files
------------

// File: rtl/redux_v_pkg.sv
// Shared types and default geometry for the fetch stage and instruction memory.
// Build option: FETCH_COUNT_EN adds the fetch_count performance counter to fetch_unit.
package redux_v_pkg;

  localparam int         DEFAULT_ADDR_BITS = 8;
  localparam logic [7:0] DEFAULT_RESET_PC  = 8'h00;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module fetch_perf_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC generation and fetch control ahead of a 1-cycle instruction memory.
// Build option: FETCH_COUNT_EN adds the fetch_count port (saturating count of fetches).
//
//   state  | meaning
//   BOOT   | first cycle after reset, RESET_PC being fetched, no valid instruction yet
//   RUN    | fetching: advance, replay on stall, or redirect on branch
//   HALTED | frozen until rst, memory output marked invalid
module fetch_unit
  import redux_v_pkg::*;
#(
  parameter int                   ADDR_BITS  = DEFAULT_ADDR_BITS,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = ADDR_BITS'(DEFAULT_RESET_PC),
  parameter int                   COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_BITS-1:0]  branch_target,
  input  logic                  halt,
  output logic [ADDR_BITS-1:0]  pc,
  output logic [ADDR_BITS-1:0]  inst_pc,
  output logic                  inst_valid,
  output logic                  halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [COUNT_BITS-1:0] fetch_count
`endif
);

  fetch_state_t         state, state_d;
  logic [ADDR_BITS-1:0] next_pc, next_pc_d, inst_pc_d;
  logic                 inst_valid_d;
  logic                 replay;

  assign replay = stall && inst_valid;
  assign halted = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      next_pc    <= RESET_PC;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_d;
      next_pc    <= next_pc_d;
      inst_pc    <= inst_pc_d;
      inst_valid <= inst_valid_d;
    end
  end

  always_comb begin
    state_d      = state;
    next_pc_d    = next_pc;
    inst_pc_d    = inst_pc;
    inst_valid_d = inst_valid;
    case (state)
      BOOT: begin
        state_d      = RUN;
        inst_pc_d    = RESET_PC;
        inst_valid_d = 1'b1;
        next_pc_d    = RESET_PC + ADDR_BITS'(1);
      end
      RUN: begin
        if (halt) begin
          state_d      = HALTED;
          inst_valid_d = 1'b0;
        end else if (branch_taken) begin
          inst_pc_d    = branch_target;
          inst_valid_d = 1'b1;
          next_pc_d    = branch_target + ADDR_BITS'(1);
        end else if (!replay) begin
          inst_pc_d    = next_pc;
          inst_valid_d = 1'b1;
          next_pc_d    = next_pc + ADDR_BITS'(1);
        end
      end
      HALTED: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d      = BOOT;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // BOOT always loads RESET_PC, so the address must be next_pc there regardless of inputs.
  always_comb begin
    pc = next_pc;
    if (state == RUN) begin
      if (branch_taken) begin
        pc = branch_target;
      end else if (replay) begin
        pc = inst_pc;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic count_inc;

  assign count_inc = (state == BOOT) ||
                     ((state == RUN) && !halt && (branch_taken || !replay));

  fetch_perf_counter #(
    .WIDTH (COUNT_BITS)
  ) u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (count_inc),
    .count (fetch_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: fetch_unit against a 1-cycle ROM model with rom[i] = i ^ 8'hA5.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       halt = 1'b0;
  logic [7:0] pc_a, inst_pc_a, instr_a;
  logic       inst_valid_a, halted_a;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_a;
  logic [15:0] fetch_count_b;
`endif

  logic       zero_b = 1'b0;
  logic [7:0] zero8_b = 8'h00;
  logic [7:0] pc_b, inst_pc_b, instr_b;
  logic       inst_valid_b, halted_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_BITS(8), .RESET_PC(8'h00), .COUNT_BITS(16)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .pc            (pc_a),
    .inst_pc       (inst_pc_a),
    .inst_valid    (inst_valid_a),
    .halted        (halted_a)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count   (fetch_count_a)
`endif
  );

  fetch_unit #(.ADDR_BITS(8), .RESET_PC(8'hFE), .COUNT_BITS(16)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .stall         (zero_b),
    .branch_taken  (zero_b),
    .branch_target (zero8_b),
    .halt          (zero_b),
    .pc            (pc_b),
    .inst_pc       (inst_pc_b),
    .inst_valid    (inst_valid_b),
    .halted        (halted_b)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count   (fetch_count_b)
`endif
  );

  always_ff @(posedge clk) begin
    instr_a <= pc_a ^ 8'hA5;
    instr_b <= pc_b ^ 8'hA5;
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk8("rst_pc", pc_a, 8'h00);
    chk8("rst_inst_pc", inst_pc_a, 8'h00);
    chk1("rst_valid", inst_valid_a, 1'b0);
    chk1("rst_halted", halted_a, 1'b0);
`ifdef FETCH_COUNT_EN
    chk16("rst_count", fetch_count_a, 16'h0000);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk8("boot_pc", pc_a, 8'h00);
    chk1("boot_valid", inst_valid_a, 1'b0);
  endtask

  logic [7:0] exp_instr_a [6] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0};
  logic [7:0] exp_ipc_b   [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [7:0] exp_instr_b [4] = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};

  initial begin
    // Power-on reset, then boot and sequential fetch on both instances.
    do_reset();
    chk8("boot_pc_b", pc_b, 8'hFE);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk8("seq_inst_pc", inst_pc_a, 8'(i));
      chk1("seq_valid", inst_valid_a, 1'b1);
      chk8("seq_instr", instr_a, exp_instr_a[i]);
      if (i < 4) begin
        chk8("wrap_inst_pc", inst_pc_b, exp_ipc_b[i]);
        chk1("wrap_valid", inst_valid_b, 1'b1);
        chk8("wrap_instr", instr_b, exp_instr_b[i]);
      end
    end

    // Stall three cycles at inst_pc 5.
    stall = 1'b1;
    #1;
    chk8("stall_pc", pc_a, 8'h05);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk8("stall_inst_pc", inst_pc_a, 8'h05);
      chk8("stall_instr", instr_a, 8'hA0);
      chk8("stall_pc_hold", pc_a, 8'h05);
      chk1("stall_valid", inst_valid_a, 1'b1);
    end
    stall = 1'b0;
    #1;
    chk8("unstall_pc", pc_a, 8'h06);
    step(1);
    chk8("unstall_inst_pc", inst_pc_a, 8'h06);
    chk8("unstall_instr", instr_a, 8'hA3);

    // Branch with simultaneous stall at inst_pc 3.
    do_reset();
    step(4);
    chk8("pre_br_inst_pc", inst_pc_a, 8'h03);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'h40;
    #1;
    chk8("br_pc", pc_a, 8'h40);
    step(1);
    chk8("br_inst_pc", inst_pc_a, 8'h40);
    chk1("br_valid", inst_valid_a, 1'b1);
    chk8("br_instr", instr_a, 8'hE5);
    stall = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk8("post_br_pc", pc_a, 8'h41);
    step(1);
    chk8("post_br_inst_pc", inst_pc_a, 8'h41);
    chk8("post_br_instr", instr_a, 8'hE4);

`ifdef FETCH_COUNT_EN
    // BOOT + 10 advances + branch count; held stalls do not.
    do_reset();
    step(11);
    chk16("cnt_after_adv", fetch_count_a, 16'd11);
    stall = 1'b1;
    step(2);
    chk16("cnt_after_stall", fetch_count_a, 16'd11);
    stall = 1'b0;
    branch_taken = 1'b1;
    branch_target = 8'h80;
    step(1);
    branch_taken = 1'b0;
    chk16("cnt_after_br", fetch_count_a, 16'd12);
    halt = 1'b1;
    step(3);
    halt = 1'b0;
    chk16("cnt_halted", fetch_count_a, 16'd12);
`endif

    // Halt at inst_pc 7, branch ignored while halted, reset recovers.
    do_reset();
    step(8);
    chk8("pre_halt_inst_pc", inst_pc_a, 8'h07);
    halt = 1'b1;
    step(1);
    chk1("halt_valid", inst_valid_a, 1'b0);
    chk1("halt_halted", halted_a, 1'b1);
    chk8("halt_pc", pc_a, 8'h08);
    chk8("halt_inst_pc", inst_pc_a, 8'h07);
    halt = 1'b0;
    branch_taken = 1'b1;
    branch_target = 8'h20;
    stall = 1'b1;
    #1;
    chk8("halt_br_pc", pc_a, 8'h08);
    step(2);
    chk8("halt_frozen_pc", pc_a, 8'h08);
    chk1("halt_frozen_valid", inst_valid_a, 1'b0);
    chk1("halt_frozen_halted", halted_a, 1'b1);
    chk8("halt_frozen_inst_pc", inst_pc_a, 8'h07);
    rst = 1'b1;
    #1;
    chk8("halt_rst_pc", pc_a, 8'h00);
    chk1("halt_rst_halted", halted_a, 1'b0);
    chk1("halt_rst_valid", inst_valid_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    branch_taken = 1'b0;
    stall = 1'b0;
    step(2);
    chk8("rerun_inst_pc", inst_pc_a, 8'h01);
    chk1("rerun_halted", halted_a, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
